// File: rtl/risc_result_display.sv
// risc_result_display
//   Captures results from a RISC core into a hold register and shows them
//   on eight LEDs (one selected byte) and a 4-digit multiplexed hex display
//   (the selected halfword). A debounced push button toggles a freeze flag
//   that stops further captures.
//
//   Optional feature: define DISPLAY_BLANK_EN to blank leading-zero digits
//   (digit 0 always lit). Without it all four digits are always lit.
//
// Ports
//   clk         system clock
//   reset       synchronous active-low reset
//   result_in   result bus from the core (DATA_W)
//   result_vld  result_in valid this cycle
//   byte_sel    byte window select (BSEL_W)
//   btn_freeze  raw asynchronous bouncing push button
//   led         selected byte of the held result
//   seg         active-low cathodes, seg[0]=a .. seg[6]=g (registered)
//   an          active-low anodes, an[0] rightmost digit (registered)
//   frozen      capture-disabled flag
module risc_result_display #(
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int DEB_CYCLES  = 1000000,
  localparam int BSEL_W     = ($clog2(DATA_W/8) < 1) ? 1 : $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] result_in,
  input  logic              result_vld,
  input  logic [BSEL_W-1:0] byte_sel,
  input  logic              btn_freeze,
  output logic [7:0]        led,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              frozen
);

  localparam int NBYTES = DATA_W / 8;
  localparam int NHW    = DATA_W / 16;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int DEB_W  = $clog2(DEB_CYCLES);

  logic [DATA_W-1:0] hold;
  logic [REF_W-1:0]  ref_cnt;
  logic [1:0]        dig;
  logic              sync0, sync1;
  logic              deb;
  logic [DEB_W-1:0]  deb_cnt;

  // ---------------- hex decode (active-low, g..a) ----------------
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // ---------------- byte / halfword windows ----------------
  // Compare-and-select loops keep out-of-range selects at zero instead of
  // indexing past the end of hold.
  logic [15:0] hw;
  always_comb begin
    led = 8'h00;
    for (int i = 0; i < NBYTES; i++)
      if (byte_sel == BSEL_W'(i)) led = hold[8*i +: 8];
  end

  always_comb begin
    hw = 16'h0000;
    for (int i = 0; i < NHW; i++)
      if ((byte_sel >> 1) == BSEL_W'(i)) hw = hold[16*i +: 16];
  end

  // ---------------- button: synchroniser + debouncer ----------------
  logic deb_settle, deb_rise;
  assign deb_settle = (sync1 != deb) && (deb_cnt == DEB_W'(DEB_CYCLES-1));
  // Toggle on the same edge the debounced level goes high.
  assign deb_rise   = deb_settle && sync1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
      frozen  <= 1'b0;
    end else begin
      sync0 <= btn_freeze;
      sync1 <= sync0;
      if (sync1 == deb)
        deb_cnt <= '0;
      else if (deb_settle) begin
        deb     <= sync1;
        deb_cnt <= '0;
      end else
        deb_cnt <= deb_cnt + 1'b1;
      if (deb_rise) frozen <= ~frozen;
    end
  end

  // ---------------- capture ----------------
  // Uses frozen before any toggle on this edge (non-blocking semantics).
  always_ff @(posedge clk) begin
    if (!reset)                     hold <= '0;
    else if (result_vld && !frozen) hold <= result_in;
  end

  // ---------------- display refresh ----------------
  logic       ref_wrap;
  logic [1:0] dig_nx;
  logic [3:0] lit;
  logic [3:0] an_nx;

  assign ref_wrap = (ref_cnt == REF_W'(REFRESH_DIV-1));
  assign dig_nx   = ref_wrap ? dig + 2'd1 : dig;

`ifdef DISPLAY_BLANK_EN
  // A digit is lit if it or any more significant nibble is non-zero.
  assign lit = {|hw[15:12], |hw[15:8], |hw[15:4], 1'b1};
`else
  assign lit = 4'b1111;
`endif

  assign an_nx = ~(4'b0001 << dig_nx) | ~lit;

  // an/seg register every cycle from the upcoming digit index so they move
  // together with the index and pick up hold changes one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_cnt <= '0;
      dig     <= 2'd0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      dig     <= dig_nx;
      an      <= an_nx;
      seg     <= hex7(hw[4*dig_nx +: 4]);
    end
  end

endmodule
